// File: rtl/hybrid_adder_pkg.sv
// Shared constants and the inter-stage record for the pipelined hybrid adder.
package hybrid_adder_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_BLOCK = 4;
   // Record fields are sized for the widest supported adder; narrower builds zero-fill.
   localparam int unsigned REC_WIDTH = 64;

   typedef struct packed {
      logic                 valid;
      logic                 carry;
      logic [REC_WIDTH-1:0] sum;
      logic [REC_WIDTH-1:0] a;
      logic [REC_WIDTH-1:0] b;
   } stage_t;

endpackage

// File: rtl/cla_block.sv
// BLOCK-wide carry-lookahead slice: generate/propagate per bit, carries chained by the CLA recurrence.
module cla_block #(
   parameter int unsigned BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < int'(BLOCK); i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      s  = p ^ c[BLOCK-1:0];
      co = c[BLOCK];
   end

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// Carry-pipelined adder: one CLA block per stage, valid/ready back-pressure, WIDTH/BLOCK >= 2.
// Optional signed-overflow output OVF is built when HYBRID_ADDER_OVF_EN is defined.
module pipelined_hybrid_adder
   import hybrid_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned BLOCK = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             C0,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout
`ifdef HYBRID_ADDER_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int unsigned NSTG = WIDTH / BLOCK;
   localparam int unsigned NREC = NSTG - 1;
   localparam int unsigned TOP  = NSTG - 1;

   stage_t           st_q [NREC];
   stage_t           st_d [NREC];
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             out_valid_q, out_valid_d;
`ifdef HYBRID_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [NSTG-1:0]  adv_c;
   logic [WIDTH-1:0] op_b_c;
   logic [BLOCK-1:0] blk_a  [NSTG];
   logic [BLOCK-1:0] blk_b  [NSTG];
   logic [BLOCK-1:0] blk_s  [NSTG];
   logic             blk_ci [NSTG];
   logic             blk_co [NSTG];

   // Back-pressure chain (a stage loads when empty or when its successor loads) and block operand routing.
   always_comb begin
      op_b_c     = sub ? ~Y : Y;
      adv_c      = '0;
      adv_c[TOP] = ~out_valid_q | out_ready;
      for (int k = int'(NREC) - 1; k >= 0; k--) begin
         adv_c[k] = ~st_q[k].valid | adv_c[k+1];
      end
      blk_a     = '{default: '0};
      blk_b     = '{default: '0};
      blk_ci    = '{default: 1'b0};
      blk_a[0]  = X[BLOCK-1:0];
      blk_b[0]  = op_b_c[BLOCK-1:0];
      blk_ci[0] = sub | C0;
      for (int k = 1; k < int'(NSTG); k++) begin
         blk_a[k]  = st_q[k-1].a[BLOCK-1:0];
         blk_b[k]  = st_q[k-1].b[BLOCK-1:0];
         blk_ci[k] = st_q[k-1].carry;
      end
   end

   for (genvar gk = 0; gk < int'(NSTG); gk++) begin : g_stage
      cla_block #(.BLOCK(BLOCK)) u_cla (
         .a  (blk_a[gk]),
         .b  (blk_b[gk]),
         .ci (blk_ci[gk]),
         .s  (blk_s[gk]),
         .co (blk_co[gk])
      );
   end

   // Operands shift down one block per stage; sum bits accumulate in place.
   always_comb begin
      st_d        = st_q;
      s_d         = s_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
`ifdef HYBRID_ADDER_OVF_EN
      ovf_d       = ovf_q;
`endif
      if (adv_c[0]) begin
         st_d[0].valid = in_valid;
         st_d[0].carry = blk_co[0];
         st_d[0].sum   = REC_WIDTH'(blk_s[0]);
         st_d[0].a     = REC_WIDTH'(X) >> BLOCK;
         st_d[0].b     = REC_WIDTH'(op_b_c) >> BLOCK;
      end
      for (int k = 1; k < int'(NREC); k++) begin
         if (adv_c[k]) begin
            st_d[k].valid = st_q[k-1].valid;
            st_d[k].carry = blk_co[k];
            st_d[k].sum   = st_q[k-1].sum | (REC_WIDTH'(blk_s[k]) << (k * BLOCK));
            st_d[k].a     = st_q[k-1].a >> BLOCK;
            st_d[k].b     = st_q[k-1].b >> BLOCK;
         end
      end
      if (adv_c[TOP]) begin
         out_valid_d = st_q[NREC-1].valid;
         s_d         = WIDTH'(st_q[NREC-1].sum | (REC_WIDTH'(blk_s[TOP]) << (TOP * BLOCK)));
         cout_d      = blk_co[TOP];
`ifdef HYBRID_ADDER_OVF_EN
         // a^b^s at the MSB recovers the carry into the MSB.
         ovf_d       = blk_a[TOP][BLOCK-1] ^ blk_b[TOP][BLOCK-1] ^ blk_s[TOP][BLOCK-1] ^ blk_co[TOP];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NREC); k++) begin
            st_q[k] <= '0;
         end
         s_q         <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef HYBRID_ADDER_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         st_q        <= st_d;
         s_q         <= s_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
`ifdef HYBRID_ADDER_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = adv_c[0];
   assign out_valid = out_valid_q;
   assign S         = s_q;
   assign Cout      = cout_q;
`ifdef HYBRID_ADDER_OVF_EN
   assign OVF       = ovf_q;
`endif

endmodule

// File: doc/pipelined_hybrid_adder.md
PIPELINED_HYBRID_ADDER -- requirements
Module: pipelined_hybrid_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The module SHALL have parameter BLOCK, default 4, giving the carry-lookahead block width in bits; WIDTH SHALL be an integer multiple of BLOCK.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The module SHALL have port in_ready, output, 1 bit: operands accepted this cycle.
REQ-007 The module SHALL have port X, input, WIDTH bits: operand A.
REQ-008 The module SHALL have port Y, input, WIDTH bits: operand B.
REQ-009 The module SHALL have port C0, input, 1 bit: carry-in.
REQ-010 The module SHALL have port sub, input, 1 bit: subtract mode (A - B).
REQ-011 The module SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The module SHALL have port S, output, WIDTH bits: sum.
REQ-014 The module SHALL have port Cout, output, 1 bit: carry-out of the MSB.

Function
REQ-015 The module SHALL have NSTG = WIDTH/BLOCK pipeline stages; stage k SHALL compute sum bits [k*BLOCK +: BLOCK] with the BLOCK-wide CLA equations Ci+1 = Gi | (Pi & Ci) and Si = Pi ^ Ci.
REQ-016 Stage k SHALL register its block carry-out as the carry-in of stage k+1, plus the completed lower sum bits, the still-unprocessed upper operand bits, and a valid bit.
REQ-017 When sub = 1, operand B SHALL be inverted on entry and the stage-0 carry-in SHALL be 1; C0 SHALL be ignored in that case.
REQ-018 When sub = 0, the stage-0 carry-in SHALL be C0.
REQ-019 A transfer SHALL occur on a clk edge where in_valid & in_ready; the result SHALL appear on S/Cout with out_valid = 1 exactly NSTG cycles later when there is no stall.
REQ-020 S and Cout SHALL be driven directly from final-stage registers (no combinational path from X/Y to S).
REQ-021 Throughput SHALL be one operation per cycle while out_ready = 1.
REQ-022 Stall: a stage SHALL advance when the next stage is empty or advancing; the last stage SHALL advance on out_ready.
REQ-023 in_ready SHALL equal (stage 0 empty) | (stage 0 advancing).
REQ-024 While out_valid = 1 and out_ready = 0, S, Cout and out_valid SHALL hold stable.
REQ-025 A full pipeline under stall SHALL hold exactly NSTG results with none lost or duplicated; when out_ready returns, results SHALL drain in acceptance order.
REQ-026 Bubbles (in_valid = 0) SHALL propagate as invalid stages and SHALL NOT corrupt neighbouring results.
REQ-027 Wrap-around: the sum SHALL be modulo 2^WIDTH, with the overflow carry reported only on Cout.

Reset
REQ-028 While rst_n = 0, all stage valid bits SHALL clear asynchronously, out_valid SHALL be 0, S SHALL be 0, and Cout SHALL be 0.
REQ-029 Assertion of rst_n mid-operation SHALL discard all in-flight results.
REQ-030 in_ready SHALL be 1 in the first cycle after release of rst_n.

Configuration
REQ-031 Macro HYBRID_ADDER_OVF_EN defined: an output port OVF (1 bit) SHALL exist, giving signed two's-complement overflow (carry into MSB XOR carry out of MSB), registered in lock-step with S and cleared at reset.
REQ-032 Macro HYBRID_ADDER_OVF_EN undefined: the OVF port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-033 Package hybrid_adder_pkg SHALL hold the default WIDTH/BLOCK constants and the per-stage record type (valid, carry, partial sum, remaining operands).
REQ-034 The module SHALL use one sub-module, cla_block (parametrised BLOCK; inputs a, b, ci; outputs s, co), instantiated NSTG times.

Verification
REQ-035 X=16'h00FF, Y=16'h0001, C0=0, sub=0 -> after 4 cycles, S=16'h0100, Cout=0.
REQ-036 X=16'hFFFF, Y=16'h0001, C0=0 -> S=16'h0000, Cout=1; with OVF enabled, OVF=0.
REQ-037 X=16'h7FFF, Y=16'h0001 -> S=16'h8000, OVF=1; sub=1, X=5, Y=7 -> S=16'hFFFE, Cout=0.
REQ-038 Issue 6 back-to-back operations with out_ready=0 -> accepts 4, in_ready=0; raise out_ready -> all 6 results exit in order.
REQ-039 Drive rst_n low with 3 results in flight -> out_valid=0 immediately; no stale result after release.
